// File: rtl/key_counter_ctrl.sv
// Multi-key pushbutton front end: synchroniser, debounce, press-edge strobe and up/down/clear counter.
// Optional auto-repeat on keys 0/1 is built when KEY_COUNTER_AUTO_REPEAT_EN is defined.
module key_counter_ctrl #(
  parameter int NUM_KEYS       = 4,
  parameter int CNT_W          = 8,
  parameter int DB_CYCLES      = 1000000,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int REPEAT_DELAY   = 25000000,
  parameter int REPEAT_RATE    = 5000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] keys_raw,
  input  logic                sat_mode,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [CNT_W-1:0]    count,
  output logic                wrap_pulse,
  output logic                at_max,
  output logic                at_min
);

  localparam int DB_W = $clog2(DB_CYCLES);
  localparam logic [NUM_KEYS-1:0] REL_LEVEL = (KEY_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [CNT_W-1:0]    CNT_MAX   = '1;

  logic [NUM_KEYS-1:0]           sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_KEYS-1:0]           level_q, level_d, level_dly_q, level_dly_d;
  logic [NUM_KEYS-1:0]           pulse_q, pulse_d, rpt_pulse;
  logic [NUM_KEYS-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [NUM_KEYS-1:0]           key_in;
  logic [CNT_W-1:0]              count_q, count_d;
  logic                          wrap_q, wrap_d;

  // Sync flops come out of reset at the released level so a held key reads as a fresh press.
  assign key_in = (KEY_ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  always_comb begin
    sync1_d     = keys_raw;
    sync2_d     = sync1_q;
    db_cnt_d    = db_cnt_q;
    level_d     = level_q;
    level_dly_d = level_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_in[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
        db_cnt_d[i] = '0;
        level_d[i]  = key_in[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

`ifdef KEY_COUNTER_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [1:0][RPT_W-1:0] rpt_q, rpt_d;
  logic [1:0]            rpt_fire;

  // Zero means idle; a repeat fires in the cycle the down-count reaches one.
  always_comb begin
    rpt_d    = rpt_q;
    rpt_fire = '0;
    for (int i = 0; i < 2; i++) begin
      if (!level_q[i]) begin
        rpt_d[i] = '0;
      end else if (!level_dly_q[i]) begin
        rpt_d[i] = RPT_W'(REPEAT_DELAY);
      end else if (rpt_q[i] == RPT_W'(1)) begin
        rpt_fire[i] = 1'b1;
        rpt_d[i]    = RPT_W'(REPEAT_RATE);
      end else if (rpt_q[i] != '0) begin
        rpt_d[i] = rpt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rpt_q <= '0;
    else        rpt_q <= rpt_d;
  end

  assign rpt_pulse = {{(NUM_KEYS-2){1'b0}}, rpt_fire};
`else
  assign rpt_pulse = '0;
`endif

  always_comb begin
    pulse_d = (level_q & ~level_dly_q) | rpt_pulse;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (pulse_q[2]) begin
      count_d = '0;
    end else if (pulse_q[0] && !pulse_q[1]) begin
      if (count_q != CNT_MAX) begin
        count_d = count_q + 1'b1;
      end else if (!sat_mode) begin
        count_d = '0;
        wrap_d  = 1'b1;
      end
    end else if (pulse_q[1] && !pulse_q[0]) begin
      if (count_q != '0) begin
        count_d = count_q - 1'b1;
      end else if (!sat_mode) begin
        count_d = CNT_MAX;
        wrap_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= REL_LEVEL;
      sync2_q     <= REL_LEVEL;
      db_cnt_q    <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      pulse_q     <= '0;
      count_q     <= '0;
      wrap_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_cnt_q    <= db_cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      pulse_q     <= pulse_d;
      count_q     <= count_d;
      wrap_q      <= wrap_d;
    end
  end

  assign key_level  = level_q;
  assign key_pulse  = pulse_q;
  assign count      = count_q;
  assign wrap_pulse = wrap_q;
  assign at_max     = (count_q == CNT_MAX);
  assign at_min     = (count_q == '0);

endmodule

// File: tb/tb_key_counter_ctrl.sv
// Scoreboard bench for key_counter_ctrl: press model pushes expected pulses, a monitor pops and checks.
module tb_key_counter_ctrl;
  localparam int DB   = 4;
  localparam int RD   = 20;
  localparam int RR   = 5;
  localparam int MAXC = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] keys_raw;
  logic       sat_mode;
  logic [3:0] key_level, key_pulse, count;
  logic       wrap_pulse, at_max, at_min;

  key_counter_ctrl #(
    .NUM_KEYS(4), .CNT_W(4), .DB_CYCLES(DB), .KEY_ACTIVE_LOW(1),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .keys_raw(keys_raw), .sat_mode(sat_mode),
    .key_level(key_level), .key_pulse(key_pulse), .count(count),
    .wrap_pulse(wrap_pulse), .at_max(at_max), .at_min(at_min)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       cyc;
    logic [3:0] mask;
    int       cnt;
    bit       wrap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mdl_count = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Counter rules as plain arithmetic on an integer.
  task automatic push_pulse(input int p, input logic [3:0] m);
    exp_t e;
    int   delta, nxt;
    bit   w = 1'b0;
    delta = (m[0] && !m[1]) ? 1 : ((m[1] && !m[0]) ? -1 : 0);
    nxt = mdl_count + delta;
    if (m[2]) nxt = 0;
    else if (nxt < 0 || nxt > MAXC) begin
      if (sat_mode) nxt = mdl_count;
      else begin
        nxt = (nxt + MAXC + 1) % (MAXC + 1);
        w = 1'b1;
      end
    end
    mdl_count = nxt;
    e.cyc = p; e.mask = m; e.cnt = nxt; e.wrap = w;
    sb.push_back(e);
  endtask

  // Raw keys in mask go pressed while cyc==n and release at cyc==n+r.
  task automatic expect_press(input logic [3:0] mask, input int n, input int r);
    int p;
    int lvl_last;
    lvl_last = n + r + DB + 1;
    p = n + DB + 3;
    push_pulse(p, mask);
`ifdef KEY_COUNTER_AUTO_REPEAT_EN
    if ((mask & 4'b0011) != 0) begin
      p += RD;
      while (p <= lvl_last + 1) begin
        push_pulse(p, mask & 4'b0011);
        p += RR;
      end
    end
`else
    if (lvl_last < 0) $display("note: negative hold window");
`endif
  endtask

  task automatic press(input logic [3:0] mask, input int r);
    int n;
    @(negedge clk);
    keys_raw = keys_raw & ~mask;
    n = cyc;
    expect_press(mask, n, r);
    repeat (r) @(negedge clk);
    keys_raw = keys_raw | mask;
    repeat (14) @(negedge clk);
  endtask

  task automatic glitch(input logic [3:0] mask, input int len);
    @(negedge clk);
    keys_raw = keys_raw & ~mask;
    repeat (len) @(negedge clk);
    keys_raw = keys_raw | mask;
    repeat (10) @(negedge clk);
    chk("glitch_level", key_level, 0);
  endtask

  // Monitor: pops one expectation per key_pulse event, checks counter one cycle later.
  bit   pending = 1'b0;
  exp_t pend;
  int   exp_count = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        pending = 1'b0;
        exp_count = 0;
      end else begin
        if (pending) begin
          chk("count", count, pend.cnt);
          chk("wrap_pulse", wrap_pulse, pend.wrap);
          chk("at_max", at_max, pend.cnt == MAXC);
          chk("at_min", at_min, pend.cnt == 0);
          exp_count = pend.cnt;
          pending = 1'b0;
        end else begin
          chk("count_idle", count, exp_count);
          chk("wrap_idle", wrap_pulse, 0);
        end
        if (key_pulse != 4'b0) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: got key_pulse %b expected none (cycle %0d)", key_pulse, cyc);
          end else begin
            pend = sb.pop_front();
            chk("pulse_mask", key_pulse, pend.mask);
            chk("pulse_cycle", cyc, pend.cyc);
            pending = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int n;
    int waited;
    rst_n = 1'b0;
    keys_raw = 4'b1110;
    sat_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_level", key_level, 0);
    chk("rst_pulse", key_pulse, 0);
    chk("rst_count", count, 0);
    chk("rst_wrap", wrap_pulse, 0);
    chk("rst_at_min", at_min, 1);

    // key0 held through reset release registers as a press
    @(negedge clk);
    rst_n = 1'b1;
    n = cyc;
    expect_press(4'b0001, n, 12);
    repeat (12) @(negedge clk);
    keys_raw[0] = 1'b1;
    repeat (14) @(negedge clk);

    // reset in the middle of a debounce: no pulse, count cleared
    @(negedge clk);
    keys_raw[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    mdl_count = 0;
    keys_raw[1] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("mid_db_reset_count", count, 0);

    for (int l = 1; l <= 3; l++) glitch(4'b0001, l);
    press(4'b0001, 12);

    sat_mode = 1'b0;
    press(4'b0100, 8);
    press(4'b0010, 8);
    press(4'b0001, 8);
    press(4'b0010, 8);

    sat_mode = 1'b1;
    press(4'b0001, 8);
    press(4'b0100, 8);
    press(4'b0010, 8);

    sat_mode = 1'b0;
    for (int k = 0; k < 5; k++) press(4'b0001, 7);
    press(4'b0011, 8);
    press(4'b0101, 8);
    press(4'b0100, 8);
    for (int k = 0; k < 3; k++) press(4'b0001, 7);
    press(4'b1000, 8);

    press(4'b0100, 8);
    press(4'b0001, 48);

    for (int k = 0; k < 40; k++) begin
      sat_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0)
        glitch(4'($urandom_range(1, 15)), $urandom_range(1, DB - 1));
      else
        press(4'($urandom_range(1, 15)), $urandom_range(6, 15));
    end

    waited = 0;
    while ((sb.size() != 0 || pending) && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (sb.size() != 0 || pending) begin
      n_fail++;
      $display("FAIL drain: got %0d outstanding pulses expected 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
